// File: rtl/ahb_pkg.sv
// Shared types for the AHB-Lite slave memory: bus encodings, slave FSM states
// and the byte-lane enable helper.
package ahb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    BUSY   = 2'b01,
    NONSEQ = 2'b10,
    SEQ    = 2'b11
  } trans_type;

  typedef enum logic [2:0] {
    BYTE      = 3'd0,
    HALF_WORD = 3'd1,
    WORD      = 3'd2,
    DWORD     = 3'd3
  } size_type;

  typedef enum logic [2:0] {
    SINGLE = 3'd0,
    INCR   = 3'd1,
    WRAP4  = 3'd2,
    INCR4  = 3'd3,
    WRAP8  = 3'd4,
    INCR8  = 3'd5,
    WRAP16 = 3'd6,
    INCR16 = 3'd7
  } burst_type;

  typedef enum logic {
    OKAY  = 1'b0,
    ERROR = 1'b1
  } resp_type;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_WAIT = 3'd1,
    ST_DATA = 3'd2,
    ST_ERR1 = 3'd3,
    ST_ERR2 = 3'd4
  } slv_state;

  // Little-endian lane enables; only meaningful for legal (aligned, <= WORD) transfers.
  function automatic logic [3:0] byte_enable(input logic [2:0] size, input logic [1:0] a);
    case (size)
      3'd0:    byte_enable = 4'b0001 << a;
      3'd1:    byte_enable = a[1] ? 4'b1100 : 4'b0011;
      default: byte_enable = 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/ahb_lite_slave_mem_if.sv
// AHB-Lite bus bundle between a master and the slave memory.
interface ahb_lite_slave_mem_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  HSEL;
    logic [ADDR_WIDTH-1:0] HADDR;
    logic                  HWRITE;
    logic [2:0]            HSIZE;
    logic [2:0]            HBURST;
    logic [3:0]            HPROT;
    logic [1:0]            HTRANS;
    logic                  HREADY;
    logic [DATA_WIDTH-1:0] HWDATA;
    logic [DATA_WIDTH-1:0] HRDATA;
    logic                  HREADYOUT;
    logic                  HRESP;

    modport master (
        output HSEL, HADDR, HWRITE, HSIZE, HBURST, HPROT, HTRANS, HREADY, HWDATA,
        input  HRDATA, HREADYOUT, HRESP
    );

    modport slave (
        input  HSEL, HADDR, HWRITE, HSIZE, HBURST, HPROT, HTRANS, HREADY, HWDATA,
        output HRDATA, HREADYOUT, HRESP
    );
endinterface

// File: rtl/ahb_slv_mem_array.sv
// Word-organised storage with synchronous byte-enabled write and combinational read.
module ahb_slv_mem_array #(
    parameter int DEPTH      = 1024,
    parameter int DATA_WIDTH = 32,
    parameter int IDX_W      = $clog2(DEPTH)
) (
    input  logic                  HCLK,
    input  logic                  we,
    input  logic [3:0]            be,
    input  logic [IDX_W-1:0]      waddr,
    input  logic [IDX_W-1:0]      raddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata
);
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    // No reset: contents survive a bus reset.
    always_ff @(posedge HCLK) begin
        if (we) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) mem_q[waddr][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
    end

    assign rdata = mem_q[raddr];
endmodule

// File: rtl/ahb_lite_slave_mem.sv
// AHB-Lite slave memory. Address phase is taken when HSEL & HREADY & HTRANS is
// NONSEQ/SEQ; a data phase completes in the cycle HREADYOUT is high.
module ahb_lite_slave_mem
    import ahb_pkg::*;
#(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int MEM_DEPTH   = 1024,
    parameter int WAIT_STATES = 0
) (
    input  logic     HCLK,
    input  logic     HRESET,
    ahb_lite_slave_mem_if.slave bus,
    output slv_state dbg_state_o
);
    localparam int                    IDX_W   = $clog2(MEM_DEPTH);
    localparam logic [ADDR_WIDTH-1:0] DEPTH_A = ADDR_WIDTH'(MEM_DEPTH);
    localparam logic [2:0]            WS      = 3'(WAIT_STATES);

    slv_state              state_q;
    logic [2:0]            cnt_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic                  write_q;
    logic [2:0]            size_q;
    logic                  hreadyout_q;
    resp_type              hresp_q;

    logic                  accept;
    logic                  addr_err;
    logic                  mem_we;
    logic [3:0]            mem_be;
    logic [IDX_W-1:0]      widx;
    logic [DATA_WIDTH-1:0] mem_rdata;
    logic                  unused_ok;

    assign accept = bus.HSEL & bus.HREADY & bus.HTRANS[1];

    always_comb begin
        addr_err = 1'b0;
        if (bus.HSIZE > 3'd2)                                     addr_err = 1'b1;
        else if (bus.HSIZE == 3'd1 && bus.HADDR[0])               addr_err = 1'b1;
        else if (bus.HSIZE == 3'd2 && bus.HADDR[1:0] != 2'b00)    addr_err = 1'b1;
        else if ({2'b00, bus.HADDR[ADDR_WIDTH-1:2]} >= DEPTH_A)   addr_err = 1'b1;
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 3'd0;
            addr_q      <= '0;
            write_q     <= 1'b0;
            size_q      <= 3'd0;
            hreadyout_q <= 1'b1;
            hresp_q     <= OKAY;
        end else begin
            case (state_q)
                ST_WAIT: begin
                    if (cnt_q == 3'd1) begin
                        state_q     <= ST_DATA;
                        hreadyout_q <= 1'b1;
                    end
                    cnt_q <= cnt_q - 3'd1;
                end
                ST_ERR1: begin
                    state_q     <= ST_ERR2;
                    hreadyout_q <= 1'b1;
                    hresp_q     <= ERROR;
                end
                // ST_IDLE, ST_DATA and ST_ERR2 all accept a pipelined address phase.
                default: begin
                    if (accept) begin
                        addr_q  <= bus.HADDR;
                        write_q <= bus.HWRITE;
                        size_q  <= bus.HSIZE;
                        if (addr_err) begin
                            state_q     <= ST_ERR1;
                            hreadyout_q <= 1'b0;
                            hresp_q     <= ERROR;
                        end else if (WS != 3'd0) begin
                            state_q     <= ST_WAIT;
                            cnt_q       <= WS;
                            hreadyout_q <= 1'b0;
                            hresp_q     <= OKAY;
                        end else begin
                            state_q     <= ST_DATA;
                            hreadyout_q <= 1'b1;
                            hresp_q     <= OKAY;
                        end
                    end else begin
                        state_q     <= ST_IDLE;
                        hreadyout_q <= 1'b1;
                        hresp_q     <= OKAY;
                    end
                end
            endcase
        end
    end

    assign widx   = addr_q[IDX_W+1:2];
    assign mem_we = (state_q == ST_DATA) && write_q;
    assign mem_be = byte_enable(size_q, addr_q[1:0]);

    ahb_slv_mem_array #(
        .DEPTH      (MEM_DEPTH),
        .DATA_WIDTH (DATA_WIDTH),
        .IDX_W      (IDX_W)
    ) u_array (
        .HCLK  (HCLK),
        .we    (mem_we),
        .be    (mem_be),
        .waddr (widx),
        .raddr (widx),
        .wdata (bus.HWDATA),
        .rdata (mem_rdata)
    );

    assign bus.HRDATA    = ((state_q == ST_DATA) && !write_q) ? mem_rdata : '0;
    assign bus.HREADYOUT = hreadyout_q;
    assign bus.HRESP     = hresp_q;
    assign dbg_state_o   = state_q;

    assign unused_ok = ^{bus.HBURST, bus.HPROT, addr_q};
endmodule

// File: tb/tb_ahb_lite_slave_mem.sv
// Bench for ahb_lite_slave_mem: three instances (0, 2 and 3 wait states) behind one
// pipelined master, checked against a byte-addressed reference memory.
module tb_ahb_lite_slave_mem;
  import ahb_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int DEPTH = 1024;

  typedef struct {
    logic [1:0]  trans;
    logic [31:0] addr;
    logic        wr;
    logic [2:0]  size;
    logic [31:0] wdata;
    bit          has_exp;
    logic [31:0] exp;
  } xfer_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // ---------------- shared master signals ----------------
  logic        m_hsel;
  logic [31:0] m_haddr;
  logic        m_hwrite;
  logic [2:0]  m_hsize;
  logic [2:0]  m_hburst;
  logic [3:0]  m_hprot;
  logic [1:0]  m_htrans;
  logic [31:0] m_hwdata;
  logic [1:0]  sel;

  logic [2:0]  rdy_v;
  logic [2:0]  resp_v;
  logic [31:0] rdata_v [3];
  slv_state    dbg_v [3];
  logic        b_ready;
  logic        b_resp;
  logic [31:0] b_rdata;

  assign b_ready = rdy_v[sel];
  assign b_resp  = resp_v[sel];
  assign b_rdata = rdata_v[sel];

  ahb_lite_slave_mem_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus_if [3] ();

  for (genvar g = 0; g < 3; g++) begin : g_dut
    assign bus_if[g].HSEL   = m_hsel && (sel == 2'(g));
    assign bus_if[g].HADDR  = m_haddr;
    assign bus_if[g].HWRITE = m_hwrite;
    assign bus_if[g].HSIZE  = m_hsize;
    assign bus_if[g].HBURST = m_hburst;
    assign bus_if[g].HPROT  = m_hprot;
    assign bus_if[g].HTRANS = m_htrans;
    assign bus_if[g].HREADY = b_ready;
    assign bus_if[g].HWDATA = m_hwdata;
    assign rdy_v[g]   = bus_if[g].HREADYOUT;
    assign resp_v[g]  = bus_if[g].HRESP;
    assign rdata_v[g] = bus_if[g].HRDATA;

    ahb_lite_slave_mem #(
      .ADDR_WIDTH  (AW),
      .DATA_WIDTH  (DW),
      .MEM_DEPTH   (DEPTH),
      .WAIT_STATES ((g == 0) ? 0 : ((g == 1) ? 2 : 3))
    ) dut (
      .HCLK        (clk),
      .HRESET      (rst),
      .bus         (bus_if[g]),
      .dbg_state_o (dbg_v[g])
    );
  end

  // ---------------- reference model ----------------
  logic [7:0] bmem   [3][4096];
  bit         bknown [3][4096];
  xfer_t      seq_q[$];
  int         n_tot = 0;
  int         n_bad = 0;

  function automatic int ws_of(logic [1:0] s);
    case (s)
      2'd0:    return 0;
      2'd1:    return 2;
      default: return 3;
    endcase
  endfunction

  function automatic bit exp_err(xfer_t x);
    if (x.size > 3'd2) return 1'b1;
    if ((x.addr & ((32'd1 << x.size) - 32'd1)) != 32'd0) return 1'b1;
    return x.addr >= 32'(4 * DEPTH);
  endfunction

  function automatic bit mdl_known(logic [1:0] s, logic [31:0] a);
    int w;
    w = int'(a[31:2]) * 4;
    return bknown[s][w] && bknown[s][w+1] && bknown[s][w+2] && bknown[s][w+3];
  endfunction

  function automatic logic [31:0] mdl_word(logic [1:0] s, logic [31:0] a);
    int w;
    w = int'(a[31:2]) * 4;
    return {bmem[s][w+3], bmem[s][w+2], bmem[s][w+1], bmem[s][w]};
  endfunction

  // Byte at address a+k travels on the lane selected by (a+k) mod 4.
  task automatic mdl_write(logic [1:0] s, xfer_t x);
    int n, ba;
    n = 1 << x.size;
    for (int k = 0; k < n; k++) begin
      ba = int'(x.addr) + k;
      bmem[s][ba]   = x.wdata[8*(ba%4) +: 8];
      bknown[s][ba] = 1'b1;
    end
  endtask

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- driver ----------------
  task automatic push(logic [1:0] t, logic [31:0] a, logic w, logic [2:0] sz, logic [31:0] d);
    xfer_t x;
    x.trans = t; x.addr = a; x.wr = w; x.size = sz; x.wdata = d;
    x.has_exp = 1'b0; x.exp = '0;
    seq_q.push_back(x);
  endtask

  task automatic push_rd(logic [1:0] t, logic [31:0] a, logic [31:0] e);
    xfer_t x;
    x.trans = t; x.addr = a; x.wr = 1'b0; x.size = 3'd2; x.wdata = '0;
    x.has_exp = 1'b1; x.exp = e;
    seq_q.push_back(x);
  endtask

  task automatic drive_idle();
    m_hsel = 1'b0; m_htrans = 2'b00; m_haddr = '0; m_hwrite = 1'b0; m_hsize = 3'd0;
  endtask

  // Runs seq_q as a pipelined master; called and returns at posedge+1.
  task automatic run_seq();
    xfer_t cur, dph;
    bit have_cur, dvalid, derr, dnull;
    logic rdy, rsp;
    logic [31:0] rd;
    int waits, guard, ws;
    string tg;
    dvalid = 1'b0; derr = 1'b0; dnull = 1'b1; waits = 0; guard = 0; ws = ws_of(sel);
    cur = '{default: '0};
    dph = '{default: '0};
    while ((seq_q.size() > 0 || dvalid) && guard < 4000) begin
      guard++;
      have_cur = (seq_q.size() > 0);
      if (have_cur) begin
        cur = seq_q[0];
        m_hsel = 1'b1; m_htrans = cur.trans; m_haddr = cur.addr;
        m_hwrite = cur.wr; m_hsize = cur.size;
      end else begin
        drive_idle();
      end
      m_hwdata = dvalid ? dph.wdata : $urandom();
      @(negedge clk);
      rdy = b_ready; rsp = b_resp; rd = b_rdata;
      if (dvalid) begin
        if (!rdy) begin
          waits++;
          chk("wait_resp", 32'(rsp), 32'(derr));
          if (waits > 12) begin
            chk("wait_timeout", 32'(waits), 32'(ws));
            seq_q.delete();
            dvalid = 1'b0;
          end
        end else begin
          if (dnull) tg = "idle_waits"; else if (derr) tg = "err_waits"; else tg = "ok_waits";
          chk(tg, 32'(waits), dnull ? 32'd0 : (derr ? 32'd1 : 32'(ws)));
          chk("resp", 32'(rsp), 32'(derr));
          if (!dnull && !dph.wr) begin
            if (derr) chk("err_rdata", rd, 32'd0);
            else begin
              if (mdl_known(sel, dph.addr)) chk("rdata", rd, mdl_word(sel, dph.addr));
              if (dph.has_exp) chk("rdata_exp", rd, dph.exp);
            end
          end
          if (!dnull && !derr && dph.wr) mdl_write(sel, dph);
          dvalid = 1'b0;
          waits = 0;
        end
      end
      @(posedge clk); #1;
      if (rdy && have_cur) begin
        dph = cur;
        dvalid = 1'b1;
        dnull = !cur.trans[1];
        derr = !dnull && exp_err(cur);
        void'(seq_q.pop_front());
      end
    end
    if (guard >= 4000) chk("seq_guard", 32'(guard), 32'd0);
    drive_idle();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    drive_idle();
    m_hburst = 3'd0; m_hprot = 4'b0011; m_hwdata = '0; sel = 2'd0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    for (int s = 0; s < 3; s++) begin
      chk("reset_ready", 32'(rdy_v[s]), 32'd1);
      chk("reset_resp", 32'(resp_v[s]), 32'd0);
      chk("reset_rdata", rdata_v[s], 32'd0);
      chk("reset_state", 32'(dbg_v[s]), 32'(ST_IDLE));
    end
    @(posedge clk); #1;

    // zero wait states: read-after-write, byte lanes, errors, burst with BUSY
    sel = 2'd0;
    push(NONSEQ, 32'h10, 1'b1, 3'd2, 32'hDEADBEEF);
    push_rd(NONSEQ, 32'h10, 32'hDEADBEEF);
    run_seq();
    push(NONSEQ, 32'h20, 1'b1, 3'd2, 32'h00000000);
    push(NONSEQ, 32'h21, 1'b1, 3'd0, 32'h00001100);
    push(NONSEQ, 32'h22, 1'b1, 3'd0, 32'h00220000);
    push_rd(NONSEQ, 32'h20, 32'h00221100);
    run_seq();
    push(NONSEQ, 32'h0, 1'b1, 3'd2, 32'h0BADF00D);
    push(NONSEQ, 32'h4, 1'b1, 3'd2, 32'h12345678);
    run_seq();
    push(NONSEQ, 32'h2, 1'b1, 3'd2, 32'hFFFFFFFF);
    push(NONSEQ, 32'h0, 1'b1, 3'd3, 32'hFFFFFFFF);
    push(NONSEQ, 32'(4 * DEPTH), 1'b1, 3'd2, 32'hFFFFFFFF);
    push(NONSEQ, 32'h2, 1'b0, 3'd2, 32'h0);
    push_rd(NONSEQ, 32'h0, 32'h0BADF00D);
    push_rd(NONSEQ, 32'h4, 32'h12345678);
    run_seq();
    m_hburst = INCR4;
    push(NONSEQ, 32'h40, 1'b1, 3'd2, 32'd1);
    push(SEQ,    32'h44, 1'b1, 3'd2, 32'd2);
    push(BUSY,   32'h48, 1'b1, 3'd2, 32'd0);
    push(SEQ,    32'h48, 1'b1, 3'd2, 32'd3);
    push(SEQ,    32'h4C, 1'b1, 3'd2, 32'd4);
    push_rd(NONSEQ, 32'h40, 32'd1);
    push_rd(SEQ,    32'h44, 32'd2);
    push_rd(SEQ,    32'h48, 32'd3);
    push_rd(SEQ,    32'h4C, 32'd4);
    run_seq();
    m_hburst = SINGLE;

    // two wait states: half-word into upper half
    sel = 2'd1;
    push(NONSEQ, 32'h4, 1'b1, 3'd2, 32'h11112222);
    push(NONSEQ, 32'h6, 1'b1, 3'd1, 32'hABCD0000);
    push_rd(NONSEQ, 32'h4, 32'hABCD2222);
    run_seq();

    // randomized traffic on the 0- and 2-wait instances
    for (int s = 0; s < 2; s++) begin
      sel = 2'(s);
      for (int w = 0; w < 16; w++) push(NONSEQ, 32'(4 * w), 1'b1, 3'd2, $urandom());
      run_seq();
      for (int i = 0; i < 80; i++) begin
        int r;
        logic [1:0] t;
        logic [2:0] sz;
        logic [31:0] a;
        r  = $urandom_range(0, 19);
        t  = (r < 2) ? IDLE : ((r < 5) ? SEQ : NONSEQ);
        sz = ($urandom_range(0, 15) == 0) ? 3'd3 : 3'($urandom_range(0, 2));
        a  = ($urandom_range(0, 15) == 0) ? 32'(4 * DEPTH + $urandom_range(0, 15))
                                          : 32'($urandom_range(0, 63));
        push(t, a, 1'($urandom_range(0, 1)), sz, $urandom());
      end
      run_seq();
    end

    // three wait states: reset in the middle of a write's wait phase
    sel = 2'd2;
    push(NONSEQ, 32'h80, 1'b1, 3'd2, 32'hCAFE0080);
    run_seq();
    m_hsel = 1'b1; m_htrans = NONSEQ; m_haddr = 32'h80; m_hwrite = 1'b1;
    m_hsize = 3'd2; m_hwdata = 32'h55AA55AA;
    @(posedge clk); #1;
    drive_idle();
    @(posedge clk); #1;
    chk("rst_pre_wait", 32'(b_ready), 32'd0);
    #2 rst = 1'b1;
    #1;
    chk("rst_ready", 32'(b_ready), 32'd1);
    chk("rst_resp", 32'(b_resp), 32'd0);
    chk("rst_rdata", b_rdata, 32'd0);
    chk("rst_state", 32'(dbg_v[2]), 32'(ST_IDLE));
    @(posedge clk); #1 rst = 1'b0;
    push_rd(NONSEQ, 32'h80, 32'hCAFE0080);
    run_seq();

    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end
endmodule
